// File: rtl/pc_pkg.sv
// Shared PC command encoding and priority resolver for the control unit and PC.
// Latency: combinational helper only.
// Backpressure: stall maps to PC_HOLD, which freezes the PC.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_cmd_t;

  // Only the strongest asserted request survives; weaker ones are dropped.
  // Order: stall > ret > call > load > en > hold.
  function automatic pc_cmd_t pc_resolve(input logic stall,
                                         input logic ret,
                                         input logic call,
                                         input logic load,
                                         input logic en);
    pc_cmd_t cmd;
    cmd = PC_HOLD;
    if (stall)     cmd = PC_HOLD;
    else if (ret)  cmd = PC_RET;
    else if (call) cmd = PC_CALL;
    else if (load) cmd = PC_LOAD;
    else if (en)   cmd = PC_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; push on full and pop on empty are silently ignored.
// Latency: push/pop take effect on the falling clock edge; data_out is the live top entry.
// Backpressure: none internally; full/empty let the owner refuse commands.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic [W-1:0]     mem [2**IDX_W];

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  // Top entry is meaningless while empty; the owner never consumes it then.
  assign data_out = mem[top_idx];

  // Stack pointer: sync reset, guarded push/pop on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entry storage: contents are don't-care after reset, so no reset here.
  always_ff @(negedge clk) begin
    if (rst_n && push && !full) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with increment, jump, call/return via an internal stack, and stall.
// Latency: one falling clock edge from command to pc_out/ack.
// Backpressure: stall freezes PC and stack; invalid call/ret is refused and flags err.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int STEP        = 1,
  parameter int RESET_VEC   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              en,
  input  logic              load,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ack,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err
);

  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);

  pc_cmd_t           cmd;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] top_addr;
  logic              ack_nxt;
  logic              err_nxt;
  logic              push;
  logic              pop;

  assign cmd    = pc_resolve(stall, ret, call, load, en);
  // Wraps modulo 2^ADDR_W; also the return address pushed by call.
  assign pc_inc = pc_out + STEP_V;

  pc_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .data_in  (pc_inc),
    .data_out (top_addr),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  // Next-state decode of the resolved command; refused call/ret only raise err.
  always_comb begin
    pc_nxt  = pc_out;
    ack_nxt = 1'b0;
    err_nxt = err;
    push    = 1'b0;
    pop     = 1'b0;
    case (cmd)
      PC_INC: begin
        pc_nxt  = pc_inc;
        ack_nxt = 1'b1;
      end
      PC_LOAD: begin
        pc_nxt  = load_addr;
        ack_nxt = 1'b1;
      end
      PC_CALL: begin
        if (stack_full) begin
          err_nxt = 1'b1;
        end else begin
          push    = 1'b1;
          pc_nxt  = load_addr;
          ack_nxt = 1'b1;
        end
      end
      PC_RET: begin
        if (stack_empty) begin
          err_nxt = 1'b1;
        end else begin
          pop     = 1'b1;
          pc_nxt  = top_addr;
          ack_nxt = 1'b1;
        end
      end
      default: begin
        pc_nxt = pc_out;
      end
    endcase
  end

  // PC, ack and sticky err registers, updated on the falling edge to match fetch timing.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      pc_out <= RESET_V;
      ack    <= 1'b0;
      err    <= 1'b0;
    end else begin
      pc_out <= pc_nxt;
      ack    <= ack_nxt;
      err    <= err_nxt;
    end
  end

endmodule
